// File: rtl/vector_multiply_arbiter.sv
// Round-robin arbiter that shares one vector multiply datapath among several requesters.
// One transaction is in flight at a time: grant, issue operands, wait for the result, respond.
module vector_multiply_arbiter #(
    parameter  int C_OP_WIDTH     = 16,
    parameter  int C_NUM_OPERANDS = 1,
    parameter  int C_NUM_REQ      = 4,
    localparam int C_DATA_WIDTH   = 2 * C_OP_WIDTH * C_NUM_OPERANDS,
    localparam int C_IDX_W        = $clog2(C_NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_datain,
    input  logic [C_NUM_REQ-1:0]              req_valid,
    output logic [C_NUM_REQ-1:0]              req_ready,
    output logic [C_DATA_WIDTH-1:0]           resp_dout,
    output logic [C_NUM_REQ-1:0]              resp_valid,
    input  logic [C_NUM_REQ-1:0]              resp_ready,
    output logic [C_DATA_WIDTH-1:0]           mult_datain,
    output logic                              mult_datain_valid,
    input  logic                              mult_datain_ready,
    input  logic [C_DATA_WIDTH-1:0]           mult_dout,
    input  logic                              mult_dout_valid,
    output logic                              mult_dout_ready,
    output logic [C_IDX_W-1:0]                grant_idx,
    output logic [31:0]                       op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state;
    logic [C_IDX_W-1:0]        last_grant;
    logic [C_IDX_W-1:0]        next_idx;
    logic                      found;
    logic                      any_valid;
    logic [C_DATA_WIDTH-1:0]   op_reg;

    assign any_valid = |req_valid;

    // Search starts just past the last served requester, so it has lowest priority.
    always_comb begin
        // NOTE: every variable assigned here gets a default first; otherwise paths that skip it infer a latch.
        next_idx = '0;
        found    = 1'b0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_grant) + 1 + k) % C_NUM_REQ]) begin
                next_idx = C_IDX_W'((int'(last_grant) + 1 + k) % C_NUM_REQ);
                found    = 1'b1;
            end
        end
    end

    // Gated by rst so no handshake can appear while the block is being reset.
    assign req_ready   = (state == IDLE && any_valid && !rst) ? (C_NUM_REQ'(1) << next_idx) : '0;
    assign mult_datain = op_reg;

    // NOTE: op_reg is pure datapath qualified by mult_datain_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_valid) begin
            op_reg <= req_datain[next_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            last_grant        <= C_IDX_W'(C_NUM_REQ - 1);
            grant_idx         <= '0;
            op_count          <= '0;
            resp_dout         <= '0;
            resp_valid        <= '0;
            mult_datain_valid <= 1'b0;
            mult_dout_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_idx         <= next_idx;
                        mult_datain_valid <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mult_datain_ready) begin
                        mult_datain_valid <= 1'b0;
                        mult_dout_ready   <= 1'b1;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (mult_dout_valid) begin
                        resp_dout       <= mult_dout;
                        mult_dout_ready <= 1'b0;
                        resp_valid      <= C_NUM_REQ'(1) << grant_idx;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    // Only the granted requester's resp_ready completes the transaction.
                    if (resp_ready[grant_idx]) begin
                        resp_valid <= '0;
                        last_grant <= grant_idx;
                        op_count   <= op_count + 32'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_multiply_arbiter.sv
// Directed bench for vector_multiply_arbiter with a 1-cycle multiplier model.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_vector_multiply_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] req_datain;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  resp_dout;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [31:0]  mult_datain;
    logic         mult_datain_valid;
    logic         mult_datain_ready;
    logic [31:0]  mult_dout;
    logic         mult_dout_valid;
    logic         mult_dout_ready;
    logic [1:0]   grant_idx;
    logic [31:0]  op_count;

    logic         model_en;
    logic         model_dv;
    logic [31:0]  model_data;
    logic         force_dv;
    logic [31:0]  force_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_multiply_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .req_datain        (req_datain),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .resp_dout         (resp_dout),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .mult_datain       (mult_datain),
        .mult_datain_valid (mult_datain_valid),
        .mult_datain_ready (mult_datain_ready),
        .mult_dout         (mult_dout),
        .mult_dout_valid   (mult_dout_valid),
        .mult_dout_ready   (mult_dout_ready),
        .grant_idx         (grant_idx),
        .op_count          (op_count)
    );

    // 1-cycle multiplier: operand1 (high half) times operand0 (low half).
    always @(posedge clk) begin
        if (rst) begin
            model_dv <= 1'b0;
        end else begin
            if (model_dv && mult_dout_ready) model_dv <= 1'b0;
            if (model_en && mult_datain_valid && mult_datain_ready) begin
                model_dv   <= 1'b1;
                model_data <= mult_datain[15:0] * mult_datain[31:16];
            end
        end
    end

    assign mult_dout_valid = model_dv | force_dv;
    assign mult_dout       = force_dv ? force_data : model_data;

    task automatic apply_reset();
        rst               = 1'b1;
        req_datain        = '0;
        req_valid         = '0;
        resp_ready        = '0;
        mult_datain_ready = 1'b1;
        model_en          = 1'b1;
        force_dv          = 1'b0;
        force_data        = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_resp_valid got %b want 0000", resp_valid); end
        n_vec++; if (mult_datain_valid !== 1'b0) begin n_err++; $display("FAIL reset_mult_datain_valid got %b want 0", mult_datain_valid); end
        n_vec++; if (mult_dout_ready !== 1'b0) begin n_err++; $display("FAIL reset_mult_dout_ready got %b want 0", mult_dout_ready); end
        n_vec++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL reset_grant_idx got %0d want 0", grant_idx); end
        n_vec++; if (op_count !== 32'd0) begin n_err++; $display("FAIL reset_op_count got %0d want 0", op_count); end
        n_vec++; if (resp_dout !== 32'd0) begin n_err++; $display("FAIL reset_resp_dout got %h want 0", resp_dout); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req_datain[64 +: 32] = 32'h0003_0005;
        req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_req_ready got %b want 0100", req_ready); end
        @(negedge clk); #1;
        req_valid = 4'b0000;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_one_cycle got %b want 0000", req_ready); end
        n_vec++; if (mult_datain !== 32'h0003_0005) begin n_err++; $display("FAIL single_mult_datain got %h want 00030005", mult_datain); end
        n_vec++; if (mult_datain_valid !== 1'b1) begin n_err++; $display("FAIL single_mult_datain_valid got %b want 1", mult_datain_valid); end
        @(negedge clk); #1;
        n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL single_resp_early got %b want 0000", resp_valid); end
        n_vec++; if (grant_idx !== 2'd2) begin n_err++; $display("FAIL single_grant_idx got %0d want 2", grant_idx); end
        @(negedge clk); #1;
        n_vec++; if (resp_valid !== 4'b0100) begin n_err++; $display("FAIL single_resp_valid got %b want 0100", resp_valid); end
        n_vec++; if (resp_dout !== 32'h0000_000F) begin n_err++; $display("FAIL single_resp_dout got %h want 0000000f", resp_dout); end
        resp_ready = 4'b0100;
        @(negedge clk); #1;
        resp_ready = 4'b0000;
        n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL single_resp_drop got %b want 0000", resp_valid); end
        n_vec++; if (op_count !== 32'd1) begin n_err++; $display("FAIL single_op_count got %0d want 1", op_count); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_prod [4] = '{32'd14, 32'd21, 32'd28, 32'd35};
        logic [3:0]  exp_rr;
        int          g = 0;
        apply_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) req_datain[i*32 +: 32] = {16'(i + 2), 16'd7};
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                exp_rr = 4'b0001 << (g % 4);
                n_vec++; if (req_ready !== exp_rr) begin n_err++; $display("FAIL rr_order got %b want %b", req_ready, exp_rr); end
                n_vec++; if (c !== 4 * g) begin n_err++; $display("FAIL rr_spacing got cycle %0d want %0d", c, 4 * g); end
                g++;
            end
            if (c % 4 == 2) begin
                n_vec++; if (grant_idx !== 2'((c - 2) / 4 % 4)) begin n_err++; $display("FAIL rr_grant_idx got %0d want %0d", grant_idx, (c - 2) / 4 % 4); end
            end
            if (c % 4 == 3) begin
                exp_rr = 4'b0001 << ((c - 3) / 4 % 4);
                n_vec++; if (resp_valid !== exp_rr) begin n_err++; $display("FAIL rr_resp_valid got %b want %b", resp_valid, exp_rr); end
                n_vec++; if (resp_dout !== exp_prod[(c - 3) / 4 % 4]) begin n_err++; $display("FAIL rr_resp_dout got %0d want %0d", resp_dout, exp_prod[(c - 3) / 4 % 4]); end
            end
            @(negedge clk);
        end
        n_vec++; if (g !== 5) begin n_err++; $display("FAIL rr_grant_count got %0d want 5", g); end
        n_vec++; if (op_count !== 32'd4) begin n_err++; $display("FAIL rr_op_count got %0d want 4", op_count); end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        mult_datain_ready    = 1'b0;
        resp_ready           = 4'b1101;
        req_datain[32 +: 32] = 32'h0009_000B;
        req_valid            = 4'b0010;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_req_ready got %b want 0010", req_ready); end
        @(negedge clk);
        req_datain[32 +: 32] = 32'hDEAD_BEEF;
        for (int s = 1; s <= 6; s++) begin
            #1;
            n_vec++; if (mult_datain !== 32'h0009_000B) begin n_err++; $display("FAIL bp_mult_datain got %h want 0009000b", mult_datain); end
            n_vec++; if (mult_datain_valid !== 1'b1) begin n_err++; $display("FAIL bp_issue_valid got %b want 1", mult_datain_valid); end
            n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_extra_grant_issue got %b want 0000", req_ready); end
            if (s == 6) mult_datain_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        n_vec++; if (mult_dout_ready !== 1'b1) begin n_err++; $display("FAIL bp_wait_ready got %b want 1", mult_dout_ready); end
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            #1;
            n_vec++; if (resp_valid !== 4'b0010) begin n_err++; $display("FAIL bp_resp_valid got %b want 0010", resp_valid); end
            n_vec++; if (resp_dout !== 32'h0000_0063) begin n_err++; $display("FAIL bp_resp_dout got %h want 00000063", resp_dout); end
            n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_extra_grant_resp got %b want 0000", req_ready); end
            n_vec++; if (op_count !== 32'd0) begin n_err++; $display("FAIL bp_op_count_early got %0d want 0", op_count); end
            @(negedge clk);
        end
        resp_ready = 4'b0010;
        req_valid  = 4'b0000;
        @(negedge clk); #1;
        resp_ready = 4'b0000;
        n_vec++; if (op_count !== 32'd1) begin n_err++; $display("FAIL bp_op_count got %0d want 1", op_count); end
        n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL bp_resp_drop got %b want 0000", resp_valid); end
    endtask

    // Runs straight after test_back_pressure: IDLE with resp_dout holding 0x63.
    task automatic test_spurious_result();
        force_data = 32'hAAAA_5555;
        force_dv   = 1'b1;
        #1;
        n_vec++; if (mult_dout_ready !== 1'b0) begin n_err++; $display("FAIL spur_dout_ready got %b want 0", mult_dout_ready); end
        @(negedge clk); #1;
        n_vec++; if (resp_dout !== 32'h0000_0063) begin n_err++; $display("FAIL spur_resp_dout got %h want 00000063", resp_dout); end
        n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL spur_resp_valid got %b want 0000", resp_valid); end
        force_dv = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (resp_dout !== 32'h0000_0063) begin n_err++; $display("FAIL spur_resp_dout_after got %h want 00000063", resp_dout); end
        n_vec++; if (op_count !== 32'd1) begin n_err++; $display("FAIL spur_op_count got %0d want 1", op_count); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        model_en              = 1'b0;
        req_datain[96 +: 32]  = 32'h0002_0002;
        req_datain[0 +: 32]   = 32'h0001_0001;
        req_valid             = 4'b1000;
        #1;
        n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rmid_req_ready got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk); #1;
        n_vec++; if (mult_dout_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_wait got %b want 1", mult_dout_ready); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (mult_dout_ready !== 1'b0) begin n_err++; $display("FAIL rmid_dout_ready got %b want 0", mult_dout_ready); end
        n_vec++; if (mult_datain_valid !== 1'b0) begin n_err++; $display("FAIL rmid_datain_valid got %b want 0", mult_datain_valid); end
        n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL rmid_resp_valid got %b want 0000", resp_valid); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_req_ready_rst got %b want 0000", req_ready); end
        n_vec++; if (op_count !== 32'd0) begin n_err++; $display("FAIL rmid_op_count got %0d want 0", op_count); end
        rst        = 1'b0;
        force_data = 32'h1234_5678;
        force_dv   = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (resp_dout !== 32'd0) begin n_err++; $display("FAIL rmid_late_result got %h want 00000000", resp_dout); end
        n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL rmid_late_resp_valid got %b want 0000", resp_valid); end
        force_dv  = 1'b0;
        req_valid = 4'b1001;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_next_grant got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_count_wrap();
        apply_reset();
        force dut.op_count = 32'hFFFF_FFFF;
        #1;
        release dut.op_count;
        #1;
        n_vec++; if (op_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload got %h want ffffffff", op_count); end
        req_datain[0 +: 32] = 32'h0004_0004;
        req_valid  = 4'b0001;
        resp_ready = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk); #1;
        n_vec++; if (resp_dout !== 32'd16) begin n_err++; $display("FAIL wrap_resp_dout got %0d want 16", resp_dout); end
        @(negedge clk); #1;
        n_vec++; if (op_count !== 32'd0) begin n_err++; $display("FAIL wrap_op_count got %h want 00000000", op_count); end
        resp_ready = 4'b0000;
    endtask

    initial begin
        rst               = 1'b1;
        req_datain        = '0;
        req_valid         = '0;
        resp_ready        = '0;
        mult_datain_ready = 1'b1;
        model_en          = 1'b1;
        force_dv          = 1'b0;
        force_data        = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_spurious_result();
        test_reset_mid_op();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
